// File: rtl/i_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one interface.
// master = fetch unit plus i_memory (the environment), slave = the cache itself.
interface i_cache_if #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                           read;
  logic [ADDRESS_WIDTH-1:0]       address;
  logic [INSTRUCTION_WIDTH-1:0]   instruction;
  logic                           busywait;
  logic                           mem_read;
  logic [ADDRESS_WIDTH-5:0]       mem_address;
  logic [4*INSTRUCTION_WIDTH-1:0] mem_readdata;
  logic                           mem_busywait;

  modport master (
    output read, address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );

  modport slave (
    input  read, address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped instruction cache: 8 lines of 4 instructions, whole-line fill on a miss.
// Optional ICACHE_STATS_EN adds hit_count / miss_count outputs.
module i_cache #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int INDEX_WIDTH       = 3
) (
  input  logic        clock,
  input  logic        reset,
  i_cache_if.slave    bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH  = ADDRESS_WIDTH - INDEX_WIDTH - 4;
  localparam int LINE_WIDTH = 4 * INSTRUCTION_WIDTH;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                   state_reg;
  logic                     first_cycle_reg;
  logic                     mem_read_reg;
  logic [ADDRESS_WIDTH-5:0] miss_addr_reg;
  logic [LINES-1:0]         valid_reg;
  logic [LINE_WIDTH-1:0]    data_mem [LINES];
  logic [TAG_WIDTH-1:0]     tag_mem  [LINES];

  logic [1:0]                   word_sel;
  logic [INDEX_WIDTH-1:0]       index;
  logic [INDEX_WIDTH-1:0]       fill_index;
  logic [TAG_WIDTH-1:0]         tag;
  logic [TAG_WIDTH-1:0]         fill_tag;
  logic [LINE_WIDTH-1:0]        line;
  logic [INSTRUCTION_WIDTH-1:0] words [4];
  logic                         hit;
  logic                         idle_hit;
  logic                         start_miss;
  logic                         fill_done;
  logic                         unused_addr_bits;

  assign word_sel         = bus.address[3:2];
  assign index            = bus.address[INDEX_WIDTH+3:4];
  assign tag              = bus.address[ADDRESS_WIDTH-1:INDEX_WIDTH+4];
  assign fill_index       = miss_addr_reg[INDEX_WIDTH-1:0];
  assign fill_tag         = miss_addr_reg[ADDRESS_WIDTH-5:INDEX_WIDTH];
  assign unused_addr_bits = ^bus.address[1:0];

  assign line = data_mem[index];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign words[gi] = line[gi*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
    end
  endgenerate

  assign hit        = bus.read & valid_reg[index] & (tag_mem[index] == tag);
  assign idle_hit   = (state_reg == IDLE) & hit;
  assign start_miss = (state_reg == IDLE) & bus.read & ~hit;
  // The first MEM_READ cycle is skipped so a stale low mem_busywait cannot end the fill.
  assign fill_done  = (state_reg == MEM_READ) & ~first_cycle_reg & ~bus.mem_busywait;

  assign bus.busywait    = ~reset & ((state_reg != IDLE) | (bus.read & ~hit));
  assign bus.instruction = (~reset & idle_hit) ? words[word_sel] : '0;
  assign bus.mem_read    = mem_read_reg & ~reset;
  assign bus.mem_address = miss_addr_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      first_cycle_reg <= 1'b0;
      mem_read_reg    <= 1'b0;
      miss_addr_reg   <= '0;
      valid_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_miss) begin
            miss_addr_reg   <= bus.address[ADDRESS_WIDTH-1:4];
            first_cycle_reg <= 1'b1;
            mem_read_reg    <= 1'b1;
            state_reg       <= MEM_READ;
          end
        end
        MEM_READ: begin
          first_cycle_reg <= 1'b0;
          if (fill_done) begin
            valid_reg[fill_index] <= 1'b1;
            mem_read_reg          <= 1'b0;
            state_reg             <= UPDATE;
          end
        end
        UPDATE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone decide what is live.
  always_ff @(posedge clock) begin
    if (!reset && fill_done) begin
      data_mem[fill_index] <= bus.mem_readdata;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (idle_hit)   hit_count  <= hit_count + 32'd1;
      if (start_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed scenarios plus random fetches against a line-level model.
// Stats checks are active when ICACHE_STATS_EN is defined.
module tb_i_cache;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total  = 0;
  int mem_latency = 3;
  int busy_cnt = 0;

  // Reference model: which block each line holds.
  logic [27:0] m_blk [8];
  bit          m_val [8];

  i_cache_if bus ();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  i_cache dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] ref_block(input logic [27:0] b);
    logic [127:0] blk;
    logic [31:0]  bb;
    blk = 128'h0000015A_02060405_00050023_00040019;
    bb  = {4'b0, b};
    if (b != 28'd0)
      for (int k = 0; k < 4; k++)
        blk[k*32 +: 32] = (bb * 32'h9E3779B1) ^ ((32'(k) + 32'd1) * 32'h7F4A7C15);
    return blk;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [127:0] blk;
    blk = ref_block(a[31:4]);
    return blk[a[3:2]*32 +: 32];
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_val[a[6:4]] && (m_blk[a[6:4]] == a[31:4]);
  endfunction

  task automatic m_fill(input logic [31:0] a);
    m_val[a[6:4]] = 1'b1;
    m_blk[a[6:4]] = a[31:4];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_val[i] = 1'b0;
  endtask

  // i_memory model: busy for mem_latency cycles after mem_read rises, then data.
  initial begin
    bus.mem_busywait = 1'b1;
    bus.mem_readdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.mem_read === 1'b1) begin
        if (busy_cnt < mem_latency) begin
          busy_cnt++;
          bus.mem_busywait = 1'b1;
        end else begin
          bus.mem_busywait = 1'b0;
          bus.mem_readdata = ref_block(bus.mem_address);
        end
      end else begin
        busy_cnt = 0;
        bus.mem_busywait = 1'b1;
      end
    end
  end

  // Holds one fetch until busywait drops; returns stall cycles and what was observed.
  task automatic drive_fetch(input logic [31:0] a, output int busy, output logic [31:0] instr,
                             output logic saw_mr, output logic [27:0] maddr);
    bus.read = 1'b1;
    bus.address = a;
    busy = 0;
    saw_mr = 1'b0;
    maddr = '0;
    @(negedge clock);
    while (bus.busywait === 1'b1 && busy < 300) begin
      if (bus.mem_read === 1'b1) begin
        saw_mr = 1'b1;
        maddr = bus.mem_address;
      end
      busy++;
      @(negedge clock);
    end
    if (bus.mem_read === 1'b1) saw_mr = 1'b1;
    instr = bus.instruction;
    @(posedge clock);
    #1;
    bus.read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.read = 1'b1;
    bus.address = 32'h0;
    repeat (2) @(negedge clock);
    total++; if (bus.busywait !== 1'b0) $display("FAIL reset_busywait: got %b expected 0", bus.busywait); else passed++;
    total++; if (bus.mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b expected 0", bus.mem_read); else passed++;
    total++; if (bus.instruction !== 32'h0) $display("FAIL reset_instr: got %h expected 0", bus.instruction); else passed++;
`ifdef ICACHE_STATS_EN
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL reset_stats: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); else passed++;
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.read = 1'b0;
    m_clear();
    @(negedge clock);
    total++; if (bus.busywait !== 1'b0 || bus.instruction !== 32'h0)
      $display("FAIL idle_after_reset: got busy=%b instr=%h expected 0/0", bus.busywait, bus.instruction); else passed++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_first_miss();
    int busy; logic [31:0] instr; logic saw; logic [27:0] ma;
    mem_latency = 3;
    drive_fetch(32'h0, busy, instr, saw, ma);
    m_fill(32'h0);
    total++; if (busy != 6) $display("FAIL first_miss_latency: got %0d stall cycles expected 6", busy); else passed++;
    total++; if (saw !== 1'b1 || ma !== 28'h0) $display("FAIL first_miss_mem_addr: got saw=%b addr=%h expected 1/0", saw, ma); else passed++;
    total++; if (instr !== 32'h00040019) $display("FAIL first_miss_instr: got %h expected 00040019", instr); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00050023; exp_w[1] = 32'h02060405; exp_w[2] = 32'h0000015A;
    bus.read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.address = 32'(i + 1) * 32'd4;
      @(negedge clock);
      total++; if (bus.instruction !== exp_w[i] || bus.busywait !== 1'b0 || bus.mem_read !== 1'b0)
        $display("FAIL b2b_hit_%0d: got instr=%h busy=%b mem_read=%b expected %h/0/0",
                 i, bus.instruction, bus.busywait, bus.mem_read, exp_w[i]);
      else passed++;
      @(posedge clock);
      #1;
    end
    bus.read = 1'b0;
    @(negedge clock);
    total++; if (bus.instruction !== 32'h0 || bus.busywait !== 1'b0)
      $display("FAIL read_low: got instr=%h busy=%b expected 0/0", bus.instruction, bus.busywait); else passed++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_replace();
    int busy; logic [31:0] instr; logic saw; logic [27:0] ma;
    mem_latency = 1;
    drive_fetch(32'h80, busy, instr, saw, ma);
    m_fill(32'h80);
    total++; if (busy != 4 || ma !== 28'h8) $display("FAIL replace_miss: got busy=%0d addr=%h expected 4/8", busy, ma); else passed++;
    total++; if (instr !== ref_word(32'h80)) $display("FAIL replace_instr: got %h expected %h", instr, ref_word(32'h80)); else passed++;
    mem_latency = 0;
    drive_fetch(32'h0, busy, instr, saw, ma);
    m_fill(32'h0);
    total++; if (busy != 4 || ma !== 28'h0) $display("FAIL refetch_miss: got busy=%0d addr=%h expected 4/0", busy, ma); else passed++;
    total++; if (instr !== 32'h00040019) $display("FAIL refetch_instr: got %h expected 00040019", instr); else passed++;
  endtask

  task automatic test_redirect();
    int cyc; logic [27:0] last_ma; int busy; logic [31:0] instr; logic saw; logic [27:0] ma;
    mem_latency = 2;
    bus.read = 1'b1;
    bus.address = 32'h100;
    cyc = 0;
    @(negedge clock);
    while (bus.mem_read !== 1'b1 && cyc < 10) begin cyc++; @(negedge clock); end
    total++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'h10)
      $display("FAIL redirect_first_fill: got mem_read=%b addr=%h expected 1/10", bus.mem_read, bus.mem_address); else passed++;
    bus.address = 32'h14;
    last_ma = bus.mem_address;
    cyc = 0;
    while (bus.busywait === 1'b1 && cyc < 300) begin
      if (bus.mem_read === 1'b1) last_ma = bus.mem_address;
      cyc++;
      @(negedge clock);
    end
    total++; if (last_ma !== 28'h1) $display("FAIL redirect_second_fill: got addr=%h expected 1", last_ma); else passed++;
    total++; if (bus.instruction !== ref_word(32'h14))
      $display("FAIL redirect_instr: got %h expected %h", bus.instruction, ref_word(32'h14)); else passed++;
    @(posedge clock);
    #1;
    bus.read = 1'b0;
    m_fill(32'h100);
    m_fill(32'h14);
    drive_fetch(32'h100, busy, instr, saw, ma);
    total++; if (busy != 0 || saw !== 1'b0 || instr !== ref_word(32'h100))
      $display("FAIL redirect_line0_hit: got busy=%0d mem_read=%b instr=%h expected 0/0/%h", busy, saw, instr, ref_word(32'h100));
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int cyc; int busy; logic [31:0] instr; logic saw; logic [27:0] ma;
    mem_latency = 6;
    bus.read = 1'b1;
    bus.address = 32'h200;
    cyc = 0;
    @(negedge clock);
    while (bus.mem_read !== 1'b1 && cyc < 10) begin cyc++; @(negedge clock); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.read = 1'b0;
    @(negedge clock);
    total++; if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0)
      $display("FAIL midfill_during_reset: got mem_read=%b busy=%b expected 0/0", bus.mem_read, bus.busywait); else passed++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_clear();
    @(negedge clock);
    total++; if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0)
      $display("FAIL midfill_after_reset: got mem_read=%b busy=%b expected 0/0", bus.mem_read, bus.busywait); else passed++;
`ifdef ICACHE_STATS_EN
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL midfill_stats: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); else passed++;
`endif
    @(posedge clock);
    #1;
    mem_latency = 0;
    drive_fetch(32'h200, busy, instr, saw, ma);
    m_fill(32'h200);
    total++; if (busy != 4 || ma !== 28'h20) $display("FAIL midfill_refetch: got busy=%0d addr=%h expected 4/20", busy, ma); else passed++;
    total++; if (instr !== ref_word(32'h200)) $display("FAIL midfill_instr: got %h expected %h", instr, ref_word(32'h200)); else passed++;
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    int busy; logic [31:0] instr; logic saw; logic [27:0] ma;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_clear();
    @(negedge clock);
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL stats_zero: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); else passed++;
    @(posedge clock);
    #1;
    mem_latency = 1;
    drive_fetch(32'h300, busy, instr, saw, ma);
    m_fill(32'h300);
    drive_fetch(32'h304, busy, instr, saw, ma);
    drive_fetch(32'h308, busy, instr, saw, ma);
    @(negedge clock);
    total++; if (hit_count !== 32'd3 || miss_count !== 32'd1)
      $display("FAIL stats_count: got hit=%0d miss=%0d expected 3/1", hit_count, miss_count); else passed++;
    @(posedge clock);
    #1;
`endif
  endtask

  task automatic test_random();
    int busy; logic [31:0] instr; logic saw; logic [27:0] ma;
    logic [31:0] a; bit exp_miss; int lat; int exp_busy;
    for (int n = 0; n < 40; n++) begin
      a = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      a = a >> 2;
      a = {a[29:0], 2'b00};
      lat = $urandom_range(0, 4);
      mem_latency = lat;
      exp_miss = !m_hit(a);
      exp_busy = exp_miss ? ((lat > 1 ? lat : 1) + 3) : 0;
      drive_fetch(a, busy, instr, saw, ma);
      if (exp_miss) m_fill(a);
      total++; if (busy != exp_busy)
        $display("FAIL rand_latency[%0d]: addr=%h got %0d expected %0d", n, a, busy, exp_busy); else passed++;
      total++; if (instr !== ref_word(a))
        $display("FAIL rand_instr[%0d]: addr=%h got %h expected %h", n, a, instr, ref_word(a)); else passed++;
      total++; if (saw !== exp_miss || (exp_miss && ma !== a[31:4]))
        $display("FAIL rand_mem[%0d]: addr=%h got mem_read=%b mem_addr=%h expected %b/%h", n, a, saw, ma, exp_miss, a[31:4]);
      else passed++;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  initial begin
    bus.read = 1'b0;
    bus.address = '0;
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_replace();
    test_redirect();
    test_reset_mid_fill();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
